// File: rtl/fetch_inst_queue.sv
// Dual-way instruction queue between the way0/way1 fetch units and decode; flush drops wrong-path entries.
// Latency: an entry written in cycle N is visible on deq0/deq1 in cycle N+1 (no bypass).
// Backpressure: enq_ready_o needs two free slots; decode pops in order via deq0_ready_i/deq1_ready_i.
module fetch_inst_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush_i,
    input  logic              way0_valid_i,
    input  logic [INST_W-1:0] way0_inst_i,
    input  logic [ADDR_W-1:0] way0_addr_i,
    input  logic              way1_valid_i,
    input  logic [INST_W-1:0] way1_inst_i,
    input  logic [ADDR_W-1:0] way1_addr_i,
    output logic              enq_ready_o,
    output logic              deq0_valid_o,
    output logic [INST_W-1:0] deq0_inst_o,
    output logic [ADDR_W-1:0] deq0_addr_o,
    output logic              deq1_valid_o,
    output logic [INST_W-1:0] deq1_inst_o,
    output logic [ADDR_W-1:0] deq1_addr_o,
    input  logic              deq0_ready_i,
    input  logic              deq1_ready_i,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_p1;
    logic [PTR_W-1:0] wr_ptr_p1;
    logic [PTR_W-1:0] way1_slot;
    logic [CNT_W-1:0] count;
    logic             push0;
    logic             push1;
    logic             pop0;
    logic             pop1;
    logic [1:0]       push_n;
    logic [1:0]       pop_n;

    // Ready depends only on registered occupancy, so fetch never sees a combinational loop.
    assign enq_ready_o = (count <= CNT_W'(DEPTH - 2));
    assign push0       = way0_valid_i & enq_ready_o & ~flush_i;
    assign push1       = way1_valid_i & enq_ready_o & ~flush_i;
    assign push_n      = {1'b0, push0} + {1'b0, push1};

    assign rd_ptr_p1   = rd_ptr + PTR_W'(1);
    assign wr_ptr_p1   = wr_ptr + PTR_W'(1);
    // A lone way1 instruction takes the head slot so program order stays dense.
    assign way1_slot   = push0 ? wr_ptr_p1 : wr_ptr;

    assign deq0_valid_o = (count >= CNT_W'(1));
    assign deq1_valid_o = (count >= CNT_W'(2));
    assign deq0_inst_o  = deq0_valid_o ? inst_mem[rd_ptr]    : '0;
    assign deq0_addr_o  = deq0_valid_o ? addr_mem[rd_ptr]    : '0;
    assign deq1_inst_o  = deq1_valid_o ? inst_mem[rd_ptr_p1] : '0;
    assign deq1_addr_o  = deq1_valid_o ? addr_mem[rd_ptr_p1] : '0;

    // Decode consumes strictly in order: deq1 only goes when deq0 goes too.
    assign pop0   = deq0_valid_o & deq0_ready_i & ~flush_i;
    assign pop1   = pop0 & deq1_valid_o & deq1_ready_i;
    assign pop_n  = {1'b0, pop0} + {1'b0, pop1};

    assign count_o = count;

    // Entry storage; contents are don't-care until covered by count, so no reset.
    always_ff @(posedge clk) begin
        if (push0) begin
            inst_mem[wr_ptr] <= way0_inst_i;
            addr_mem[wr_ptr] <= way0_addr_i;
        end
        if (push1) begin
            inst_mem[way1_slot] <= way1_inst_i;
            addr_mem[way1_slot] <= way1_addr_i;
        end
    end

    // Pointer and occupancy update; reset dominates flush, flush dominates push/pop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop_n);
            wr_ptr <= wr_ptr + PTR_W'(push_n);
            count  <= count + CNT_W'(push_n) - CNT_W'(pop_n);
        end
    end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Bench for fetch_inst_queue: directed table of cycles with hand-derived results, then random traffic.
// Latency: outputs are compared 1 time unit after each rising edge.
// Backpressure: the reference queue applies the two-free-slot enqueue rule and in-order pops.
module tb_fetch_inst_queue;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              flush_i;
    logic              way0_valid_i;
    logic [INST_W-1:0] way0_inst_i;
    logic [ADDR_W-1:0] way0_addr_i;
    logic              way1_valid_i;
    logic [INST_W-1:0] way1_inst_i;
    logic [ADDR_W-1:0] way1_addr_i;
    logic              enq_ready_o;
    logic              deq0_valid_o;
    logic [INST_W-1:0] deq0_inst_o;
    logic [ADDR_W-1:0] deq0_addr_o;
    logic              deq1_valid_o;
    logic [INST_W-1:0] deq1_inst_o;
    logic [ADDR_W-1:0] deq1_addr_o;
    logic              deq0_ready_i;
    logic              deq1_ready_i;
    logic [3:0]        count_o;

    fetch_inst_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
        .way0_valid_i(way0_valid_i), .way0_inst_i(way0_inst_i), .way0_addr_i(way0_addr_i),
        .way1_valid_i(way1_valid_i), .way1_inst_i(way1_inst_i), .way1_addr_i(way1_addr_i),
        .enq_ready_o(enq_ready_o),
        .deq0_valid_o(deq0_valid_o), .deq0_inst_o(deq0_inst_o), .deq0_addr_o(deq0_addr_o),
        .deq1_valid_o(deq1_valid_o), .deq1_inst_o(deq1_inst_o), .deq1_addr_o(deq1_addr_o),
        .deq0_ready_i(deq0_ready_i), .deq1_ready_i(deq1_ready_i), .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] addr;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic        rst_n, fl, v0, v1, r0, r1;
        logic [31:0] a0, a1;
        int          e_cnt;
        logic        e_enq, e_v0, e_v1;
        logic [31:0] e_a0, e_a1;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic [31:0] a, input logic way);
        return way ? (32'h0010_0093 ^ {a[15:0], 16'h0}) : (32'h0000_0013 ^ {a[15:0], 16'h0});
    endfunction

    // Reference: occupancy is the queue length; pops are judged on the pre-edge length.
    task automatic model_update();
        int n;
        logic enq, p0, p1;
        if (!reset_n || flush_i) begin
            q.delete();
        end else begin
            n   = q.size();
            enq = (DEPTH - n) >= 2;
            p0  = (n >= 1) && deq0_ready_i;
            p1  = p0 && (n >= 2) && deq1_ready_i;
            if (p0) void'(q.pop_front());
            if (p1) void'(q.pop_front());
            if (enq && way0_valid_i) q.push_back('{inst: way0_inst_i, addr: way0_addr_i});
            if (enq && way1_valid_i) q.push_back('{inst: way1_inst_i, addr: way1_addr_i});
        end
    endtask

    task automatic model_check();
        int n;
        n = q.size();
        chk("overflow", 64'(count_o > 4'(DEPTH)), 64'd0);
        chk("count", 64'(count_o), 64'(n));
        chk("enq_ready", 64'(enq_ready_o), 64'((DEPTH - n) >= 2));
        chk("deq0_valid", 64'(deq0_valid_o), 64'(n >= 1));
        chk("deq1_valid", 64'(deq1_valid_o), 64'(n >= 2));
        chk("deq0_inst", 64'(deq0_inst_o), 64'((n >= 1) ? q[0].inst : 32'h0));
        chk("deq0_addr", 64'(deq0_addr_o), 64'((n >= 1) ? q[0].addr : 32'h0));
        chk("deq1_inst", 64'(deq1_inst_o), 64'((n >= 2) ? q[1].inst : 32'h0));
        chk("deq1_addr", 64'(deq1_addr_o), 64'((n >= 2) ? q[1].addr : 32'h0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        model_check();
    endtask

    task automatic drive(input logic rst_n, input logic fl, input logic v0, input logic [31:0] a0,
                         input logic v1, input logic [31:0] a1, input logic r0, input logic r1);
        reset_n      = rst_n;
        flush_i      = fl;
        way0_valid_i = v0;
        way0_addr_i  = a0;
        way0_inst_i  = mk_inst(a0, 1'b0);
        way1_valid_i = v1;
        way1_addr_i  = a1;
        way1_inst_i  = mk_inst(a1, 1'b1);
        deq0_ready_i = r0;
        deq1_ready_i = r1;
    endtask

    function automatic vec_t mkv(input logic rst_n, input logic fl, input logic v0, input logic [31:0] a0,
                                 input logic v1, input logic [31:0] a1, input logic r0, input logic r1,
                                 input int e_cnt, input logic e_enq, input logic e_v0, input logic e_v1,
                                 input logic [31:0] e_a0, input logic [31:0] e_a1);
        vec_t v;
        v.rst_n = rst_n; v.fl = fl; v.v0 = v0; v.a0 = a0; v.v1 = v1; v.a1 = a1;
        v.r0 = r0; v.r1 = r1; v.e_cnt = e_cnt; v.e_enq = e_enq; v.e_v0 = e_v0;
        v.e_v1 = e_v1; v.e_a0 = e_a0; v.e_a1 = e_a1;
        return v;
    endfunction

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Each row: inputs for one cycle, then the outputs expected after that edge.
        //            rst fl v0 a0            v1 a1            r0 r1  cnt enq dv0 dv1 deq0_addr     deq1_addr
        vecs.push_back(mkv(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 1, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mkv(1, 0, 1, 32'h80000000, 1, 32'h80000004, 0, 0, 2, 1, 1, 1, 32'h80000000, 32'h80000004));
        vecs.push_back(mkv(1, 0, 1, 32'h80000000, 1, 32'h80000004, 0, 0, 4, 1, 1, 1, 32'h80000000, 32'h80000004));
        vecs.push_back(mkv(1, 0, 1, 32'h80000000, 1, 32'h80000004, 0, 0, 6, 1, 1, 1, 32'h80000000, 32'h80000004));
        vecs.push_back(mkv(1, 0, 1, 32'h80000000, 1, 32'h80000004, 0, 0, 8, 0, 1, 1, 32'h80000000, 32'h80000004));
        vecs.push_back(mkv(1, 0, 1, 32'h80000000, 1, 32'h80000004, 0, 0, 8, 0, 1, 1, 32'h80000000, 32'h80000004));
        vecs.push_back(mkv(1, 1, 1, 32'h800000F0, 1, 32'h800000F4, 1, 1, 0, 1, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mkv(1, 0, 1, 32'h80000000, 1, 32'h80000004, 0, 0, 2, 1, 1, 1, 32'h80000000, 32'h80000004));
        vecs.push_back(mkv(1, 0, 1, 32'h80000008, 0, 32'h0,        0, 0, 3, 1, 1, 1, 32'h80000000, 32'h80000004));
        vecs.push_back(mkv(1, 0, 0, 32'h0,        0, 32'h0,        1, 1, 1, 1, 1, 0, 32'h80000008, 32'h0));
        vecs.push_back(mkv(1, 0, 1, 32'h8000000C, 1, 32'h80000010, 0, 0, 3, 1, 1, 1, 32'h80000008, 32'h8000000C));
        vecs.push_back(mkv(1, 0, 0, 32'h0,        1, 32'h80000014, 0, 0, 4, 1, 1, 1, 32'h80000008, 32'h8000000C));
        vecs.push_back(mkv(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 4, 1, 1, 1, 32'h80000008, 32'h8000000C));
        vecs.push_back(mkv(1, 0, 1, 32'h80000018, 0, 32'h0,        0, 0, 5, 1, 1, 1, 32'h80000008, 32'h8000000C));
        vecs.push_back(mkv(1, 1, 1, 32'h800000F0, 1, 32'h800000F4, 1, 1, 0, 1, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mkv(1, 0, 0, 32'h0,        1, 32'h80000010, 0, 0, 1, 1, 1, 0, 32'h80000010, 32'h0));
        vecs.push_back(mkv(1, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 1, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mkv(1, 0, 1, 32'h80000020, 1, 32'h80000024, 0, 0, 2, 1, 1, 1, 32'h80000020, 32'h80000024));
        vecs.push_back(mkv(1, 0, 1, 32'h80000028, 1, 32'h8000002C, 1, 1, 2, 1, 1, 1, 32'h80000028, 32'h8000002C));
        vecs.push_back(mkv(1, 0, 1, 32'h80000030, 1, 32'h80000034, 1, 1, 2, 1, 1, 1, 32'h80000030, 32'h80000034));
        vecs.push_back(mkv(1, 0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 1, 0, 0, 32'h0,        32'h0));
        // rd_ptr = wr_ptr = 7 here: the next pair straddles slots 7 and 0.
        vecs.push_back(mkv(1, 0, 1, 32'h80000100, 1, 32'h80000104, 0, 0, 2, 1, 1, 1, 32'h80000100, 32'h80000104));
        vecs.push_back(mkv(1, 0, 1, 32'h80000108, 1, 32'h8000010C, 1, 1, 2, 1, 1, 1, 32'h80000108, 32'h8000010C));
        vecs.push_back(mkv(0, 1, 1, 32'h80000200, 1, 32'h80000204, 1, 1, 0, 1, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mkv(1, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 1, 0, 0, 32'h0,        32'h0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].fl, vecs[i].v0, vecs[i].a0,
                  vecs[i].v1, vecs[i].a1, vecs[i].r0, vecs[i].r1);
            tick();
            chk($sformatf("vec%0d_count", i), 64'(count_o), 64'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_enq_ready", i), 64'(enq_ready_o), 64'(vecs[i].e_enq));
            chk($sformatf("vec%0d_deq0_valid", i), 64'(deq0_valid_o), 64'(vecs[i].e_v0));
            chk($sformatf("vec%0d_deq1_valid", i), 64'(deq1_valid_o), 64'(vecs[i].e_v1));
            chk($sformatf("vec%0d_deq0_addr", i), 64'(deq0_addr_o), 64'(vecs[i].e_a0));
            chk($sformatf("vec%0d_deq1_addr", i), 64'(deq1_addr_o), 64'(vecs[i].e_a1));
            chk($sformatf("vec%0d_deq0_inst", i), 64'(deq0_inst_o),
                64'(vecs[i].e_v0 ? mk_inst(vecs[i].e_a0, vecs[i].e_a0 == 32'h80000010 && i == 15) : 32'h0));
        end

        // Random traffic; ready bias shifts per block so the queue spends time both full and empty.
        for (int blk = 0; blk < 8; blk++) begin
            for (int c = 0; c < 300; c++) begin
                reset_n      = ($urandom_range(0, 299) != 0);
                flush_i      = ($urandom_range(0, 39) == 0);
                way0_valid_i = ($urandom_range(0, 3) != 0);
                way0_addr_i  = $urandom;
                way0_inst_i  = $urandom;
                way1_valid_i = ($urandom_range(0, 3) != 0);
                way1_addr_i  = $urandom;
                way1_inst_i  = $urandom;
                deq0_ready_i = ($urandom_range(0, 7) < 1 + blk);
                deq1_ready_i = ($urandom_range(0, 7) < 8 - blk);
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
